// File: rtl/tl_a_arb_if.sv
// Signal bundle for the two-requester TileLink A/D arbiter.
// The master modport is the arbiter's view; slave is the requesters/slave-side environment.
interface tl_a_arb_if #(
  parameter int SRC_W = 6
);
  logic              in0_a_valid, in0_a_ready;
  logic [2:0]        in0_a_opcode, in0_a_param;
  logic [3:0]        in0_a_size;
  logic [SRC_W-1:0]  in0_a_source;
  logic [31:0]       in0_a_address;
  logic [3:0]        in0_a_mask;
  logic [31:0]       in0_a_data;
  logic              in0_a_corrupt;

  logic              in1_a_valid, in1_a_ready;
  logic [2:0]        in1_a_opcode, in1_a_param;
  logic [3:0]        in1_a_size;
  logic [SRC_W-1:0]  in1_a_source;
  logic [31:0]       in1_a_address;
  logic [3:0]        in1_a_mask;
  logic [31:0]       in1_a_data;
  logic              in1_a_corrupt;

  logic              out_a_valid, out_a_ready;
  logic [2:0]        out_a_opcode, out_a_param;
  logic [3:0]        out_a_size;
  logic [SRC_W:0]    out_a_source;
  logic [31:0]       out_a_address;
  logic [3:0]        out_a_mask;
  logic [31:0]       out_a_data;
  logic              out_a_corrupt;

  logic              d_valid, d_ready;
  logic [SRC_W:0]    d_source;
  logic [2:0]        d_opcode;
  logic [3:0]        d_size;
  logic [31:0]       d_data;
  logic              d_denied;

  logic              in0_d_valid, in0_d_ready;
  logic [SRC_W-1:0]  in0_d_source;
  logic [2:0]        in0_d_opcode;
  logic [3:0]        in0_d_size;
  logic [31:0]       in0_d_data;
  logic              in0_d_denied;

  logic              in1_d_valid, in1_d_ready;
  logic [SRC_W-1:0]  in1_d_source;
  logic [2:0]        in1_d_opcode;
  logic [3:0]        in1_d_size;
  logic [31:0]       in1_d_data;
  logic              in1_d_denied;

  modport master (
    input  in0_a_valid, in0_a_opcode, in0_a_param, in0_a_size, in0_a_source,
           in0_a_address, in0_a_mask, in0_a_data, in0_a_corrupt,
    output in0_a_ready,
    input  in1_a_valid, in1_a_opcode, in1_a_param, in1_a_size, in1_a_source,
           in1_a_address, in1_a_mask, in1_a_data, in1_a_corrupt,
    output in1_a_ready,
    output out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source,
           out_a_address, out_a_mask, out_a_data, out_a_corrupt,
    input  out_a_ready,
    input  d_valid, d_source, d_opcode, d_size, d_data, d_denied,
    output d_ready,
    output in0_d_valid, in0_d_source, in0_d_opcode, in0_d_size, in0_d_data, in0_d_denied,
    input  in0_d_ready,
    output in1_d_valid, in1_d_source, in1_d_opcode, in1_d_size, in1_d_data, in1_d_denied,
    input  in1_d_ready
  );

  modport slave (
    output in0_a_valid, in0_a_opcode, in0_a_param, in0_a_size, in0_a_source,
           in0_a_address, in0_a_mask, in0_a_data, in0_a_corrupt,
    input  in0_a_ready,
    output in1_a_valid, in1_a_opcode, in1_a_param, in1_a_size, in1_a_source,
           in1_a_address, in1_a_mask, in1_a_data, in1_a_corrupt,
    input  in1_a_ready,
    input  out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source,
           out_a_address, out_a_mask, out_a_data, out_a_corrupt,
    output out_a_ready,
    output d_valid, d_source, d_opcode, d_size, d_data, d_denied,
    input  d_ready,
    input  in0_d_valid, in0_d_source, in0_d_opcode, in0_d_size, in0_d_data, in0_d_denied,
    output in0_d_ready,
    input  in1_d_valid, in1_d_source, in1_d_opcode, in1_d_size, in1_d_data, in1_d_denied,
    output in1_d_ready
  );
endinterface

// File: rtl/tl_a_arb.sv
// Two-requester TileLink A-channel arbiter with burst locking and D-channel return routing.
// Define TL_A_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
//
// state | meaning
// IDLE  | arbitrate each cycle; single-beat messages complete here
// BURST | locked to lock_q until the remaining beats of a Put burst have fired
module tl_a_arb #(
  parameter int SRC_W    = 6,
  parameter int MAX_SIZE = 6
) (
  input logic       clock,
  input logic       reset_n,
  tl_a_arb_if.master bus
);
  localparam int CNT_W = (MAX_SIZE > 3) ? MAX_SIZE - 2 : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;
`ifndef TL_A_ARB_FIXED_PRIO_EN
  logic             rr_q, rr_d;
`endif

  logic             win_id;
  logic             win_valid;
  logic             fire;
  logic             multi;
  logic [3:0]       shift;
  logic [CNT_W:0]   beats;
  logic [CNT_W:0]   load;

  always_comb begin
    win_id = 1'b0;
    if (state_q == BURST) begin
      win_id = lock_q;
    end else if (bus.in0_a_valid && bus.in1_a_valid) begin
`ifdef TL_A_ARB_FIXED_PRIO_EN
      win_id = 1'b0;
`else
      win_id = rr_q;
`endif
    end else if (bus.in1_a_valid) begin
      win_id = 1'b1;
    end
  end

  assign win_valid = win_id ? bus.in1_a_valid : bus.in0_a_valid;
  assign bus.out_a_valid = reset_n & win_valid;
  assign bus.in0_a_ready = reset_n & bus.out_a_ready & ~win_id;
  assign bus.in1_a_ready = reset_n & bus.out_a_ready & win_id;
  assign fire = bus.out_a_valid & bus.out_a_ready;

  assign bus.out_a_opcode  = win_id ? bus.in1_a_opcode  : bus.in0_a_opcode;
  assign bus.out_a_param   = win_id ? bus.in1_a_param   : bus.in0_a_param;
  assign bus.out_a_size    = win_id ? bus.in1_a_size    : bus.in0_a_size;
  assign bus.out_a_source  = {win_id, win_id ? bus.in1_a_source : bus.in0_a_source};
  assign bus.out_a_address = win_id ? bus.in1_a_address : bus.in0_a_address;
  assign bus.out_a_mask    = win_id ? bus.in1_a_mask    : bus.in0_a_mask;
  assign bus.out_a_data    = win_id ? bus.in1_a_data    : bus.in0_a_data;
  assign bus.out_a_corrupt = win_id ? bus.in1_a_corrupt : bus.in0_a_corrupt;

  // Sizes above MAX_SIZE are illegal and are passed through as single beats.
  assign multi = (bus.out_a_opcode == 3'd0 || bus.out_a_opcode == 3'd1) &&
                 (bus.out_a_size > 4'd2) && (bus.out_a_size <= 4'(MAX_SIZE));
  assign shift = bus.out_a_size - 4'd2;
  assign beats = (CNT_W+1)'(1) << shift;
  assign load  = beats - (CNT_W+1)'(2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
`ifndef TL_A_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (multi) begin
            state_d = BURST;
            cnt_d   = load[CNT_W-1:0];
            lock_d  = win_id;
          end else begin
`ifndef TL_A_ARB_FIXED_PRIO_EN
            rr_d = ~win_id;
`endif
          end
        end
      end
      BURST: begin
        if (fire) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
`ifndef TL_A_ARB_FIXED_PRIO_EN
            rr_d    = ~lock_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
`ifndef TL_A_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
`ifndef TL_A_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // D responses are steered by the requester-ID bit prepended on the A side.
  assign bus.in0_d_valid  = reset_n & bus.d_valid & ~bus.d_source[SRC_W];
  assign bus.in1_d_valid  = reset_n & bus.d_valid &  bus.d_source[SRC_W];
  assign bus.d_ready      = reset_n & (bus.d_source[SRC_W] ? bus.in1_d_ready : bus.in0_d_ready);
  assign bus.in0_d_source = bus.d_source[SRC_W-1:0];
  assign bus.in1_d_source = bus.d_source[SRC_W-1:0];
  assign bus.in0_d_opcode = bus.d_opcode;
  assign bus.in1_d_opcode = bus.d_opcode;
  assign bus.in0_d_size   = bus.d_size;
  assign bus.in1_d_size   = bus.d_size;
  assign bus.in0_d_data   = bus.d_data;
  assign bus.in1_d_data   = bus.d_data;
  assign bus.in0_d_denied = bus.d_denied;
  assign bus.in1_d_denied = bus.d_denied;
endmodule

// File: tb/tb_tl_a_arb.sv
// Scoreboard bench for tl_a_arb: stimulus pushes expected A-channel fires, a monitor pops and compares.
module tb_tl_a_arb;
  localparam int SRC_W = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tl_a_arb_if #(.SRC_W(SRC_W)) bus ();
  tl_a_arb #(.SRC_W(SRC_W), .MAX_SIZE(6)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [6:0]  src;
    logic [2:0]  op;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [6:0] src, input logic [2:0] op, input logic [3:0] sz,
                               input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.src = src; e.op = op; e.size = sz; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (reset_n && bus.out_a_valid && bus.out_a_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fire actual_source=%0h required=none", bus.out_a_source);
      end else begin
        mon_e = exp_q.pop_front();
        check("a_source",  32'(bus.out_a_source), 32'(mon_e.src));
        check("a_opcode",  32'(bus.out_a_opcode), 32'(mon_e.op));
        check("a_size",    32'(bus.out_a_size),   32'(mon_e.size));
        check("a_address", bus.out_a_address,     mon_e.addr);
        check("a_data",    bus.out_a_data,        mon_e.data);
      end
    end
  end

  initial begin
    bus.out_a_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rdy_mode == 1) bus.out_a_ready = ~bus.out_a_ready;
      else bus.out_a_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  function automatic logic rdy(input int n);
    return (n == 0) ? bus.in0_a_ready : bus.in1_a_ready;
  endfunction

  task automatic set_req(input int n, input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [5:0] src, input logic [31:0] addr, input logic [31:0] data);
    if (n == 0) begin
      bus.in0_a_valid = v; bus.in0_a_opcode = op; bus.in0_a_param = 3'd0; bus.in0_a_size = sz;
      bus.in0_a_source = src; bus.in0_a_address = addr; bus.in0_a_mask = 4'hf;
      bus.in0_a_data = data; bus.in0_a_corrupt = 1'b0;
    end else begin
      bus.in1_a_valid = v; bus.in1_a_opcode = op; bus.in1_a_param = 3'd0; bus.in1_a_size = sz;
      bus.in1_a_source = src; bus.in1_a_address = addr; bus.in1_a_mask = 4'hf;
      bus.in1_a_data = data; bus.in1_a_corrupt = 1'b0;
    end
  endtask

  // Waits for requester n to be granted; returns the number of stalled cycles.
  task automatic wait_fire(input int n, output int waitc, output bit ok);
    waitc = 0;
    ok = 1'b0;
    while (waitc <= 50) begin
      @(negedge clock);
      if (rdy(n)) begin
        ok = 1'b1;
        break;
      end
      waitc++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout_req%0d actual=no_grant required=grant", n);
    end
  endtask

  task automatic send(input int n, input logic [2:0] op, input logic [3:0] sz, input logic [5:0] src,
                      input logic [31:0] addr, input logic [31:0] dbase, input int beats, output int lat);
    int w;
    bit ok;
    lat = 0;
    for (int b = 0; b < beats; b++) begin
      set_req(n, 1'b1, op, sz, src, addr, dbase + 32'(b));
      wait_fire(n, w, ok);
      if (b == 0) lat = w;
      @(posedge clock);
      #1;
      if (!ok) break;
    end
    set_req(n, 1'b0, op, sz, src, addr, dbase);
  endtask

  task automatic drain(input string name);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover actual=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  int l0, l1, w;
  bit ok;

  initial begin
    set_req(0, 1'b1, 3'd4, 4'd2, 6'h01, 32'h0, 32'h0);
    set_req(1, 1'b1, 3'd4, 4'd2, 6'h02, 32'h0, 32'h0);
    bus.d_valid = 1'b1; bus.d_source = 7'h45; bus.d_opcode = 3'd1; bus.d_size = 4'd2;
    bus.d_data = 32'h0; bus.d_denied = 1'b0;
    bus.in0_d_ready = 1'b1; bus.in1_d_ready = 1'b1;

    // Reset: everything quiet even with requests and responses pending.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_a_valid", 32'(bus.out_a_valid), 0);
    check("rst_in0_a_ready", 32'(bus.in0_a_ready), 0);
    check("rst_in1_a_ready", 32'(bus.in1_a_ready), 0);
    check("rst_d_ready",     32'(bus.d_ready), 0);
    check("rst_in0_d_valid", 32'(bus.in0_d_valid), 0);
    check("rst_in1_d_valid", 32'(bus.in1_d_valid), 0);
    @(posedge clock);
    #1;
    set_req(0, 1'b0, 3'd4, 4'd2, 6'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'd4, 4'd2, 6'h0, 32'h0, 32'h0);
    bus.d_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Contention on single-beat Gets: in0 first (zero latency), then in1.
    push(7'h11, 3'd4, 4'd2, 32'h1000, 32'hD0);
    push(7'h62, 3'd4, 4'd2, 32'h2000, 32'hE0);
    fork
      send(0, 3'd4, 4'd2, 6'h11, 32'h1000, 32'hD0, 1, l0);
      send(1, 3'd4, 4'd2, 6'h22, 32'h2000, 32'hE0, 1, l1);
    join
    check("lat_in0_first", 32'(l0), 0);
    check("lat_in1_second", 32'(l1), 1);
    drain("rr_single");

    // 4-beat PutFull on in0 holds off in1 for all four beats.
    for (int i = 0; i < 4; i++) push(7'h03, 3'd0, 4'd4, 32'h100, 32'hA0 + 32'(i));
    push(7'h47, 3'd4, 4'd2, 32'h200, 32'hB0);
    fork
      send(0, 3'd0, 4'd4, 6'h03, 32'h100, 32'hA0, 4, l0);
      send(1, 3'd4, 4'd2, 6'h07, 32'h200, 32'hB0, 1, l1);
    join
    check("lat_in1_after_burst", 32'(l1), 4);
    drain("burst4");

    // Same burst with out_a_ready toggling: lock holds, only fires advance.
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) push(7'h0A, 3'd1, 4'd4, 32'h180, 32'hC0 + 32'(i));
    push(7'h4B, 3'd4, 4'd2, 32'h280, 32'hC8);
    fork
      send(0, 3'd1, 4'd4, 6'h0A, 32'h180, 32'hC0, 4, l0);
      send(1, 3'd4, 4'd2, 6'h0B, 32'h280, 32'hC8, 1, l1);
    join
    rdy_mode = 0;
    drain("burst_toggle");
    @(posedge clock);
    #1;

    // Reset mid-burst: after release, rr_ptr and state are back to IDLE/0.
    push(7'h01, 3'd4, 4'd2, 32'h10, 32'h10);
    send(0, 3'd4, 4'd2, 6'h01, 32'h10, 32'h10, 1, l0);
    push(7'h42, 3'd0, 4'd4, 32'h20, 32'h20);
    push(7'h42, 3'd0, 4'd4, 32'h20, 32'h21);
    set_req(1, 1'b1, 3'd0, 4'd4, 6'h02, 32'h20, 32'h20);
    wait_fire(1, w, ok);
    @(posedge clock);
    #1;
    set_req(1, 1'b1, 3'd0, 4'd4, 6'h02, 32'h20, 32'h21);
    wait_fire(1, w, ok);
    @(posedge clock);
    #1;
    set_req(1, 1'b1, 3'd0, 4'd4, 6'h02, 32'h20, 32'h22);
    set_req(0, 1'b1, 3'd4, 4'd2, 6'h01, 32'h30, 32'h31);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_out_a_valid", 32'(bus.out_a_valid), 0);
    check("midrst_in0_a_ready", 32'(bus.in0_a_ready), 0);
    check("midrst_in1_a_ready", 32'(bus.in1_a_ready), 0);
    @(posedge clock);
    #1;
    set_req(0, 1'b0, 3'd4, 4'd2, 6'h01, 32'h30, 32'h31);
    set_req(1, 1'b0, 3'd4, 4'd2, 6'h02, 32'h40, 32'h30);
    reset_n = 1'b1;
    drain("pre_reset_beats");
    push(7'h01, 3'd4, 4'd2, 32'h30, 32'h31);
    push(7'h42, 3'd4, 4'd2, 32'h40, 32'h30);
    fork
      send(0, 3'd4, 4'd2, 6'h01, 32'h30, 32'h31, 1, l0);
      send(1, 3'd4, 4'd2, 6'h02, 32'h40, 32'h30, 1, l1);
    join
    check("post_reset_in0_first", 32'(l0), 0);
    drain("post_reset");

    // D-channel routing by the top source bit.
    bus.d_valid = 1'b1; bus.d_source = 7'h45; bus.d_data = 32'h12345678;
    bus.d_opcode = 3'd1; bus.d_size = 4'd2; bus.d_denied = 1'b1;
    bus.in0_d_ready = 1'b0; bus.in1_d_ready = 1'b1;
    @(negedge clock);
    check("d45_in1_d_valid",  32'(bus.in1_d_valid), 1);
    check("d45_in1_d_source", 32'(bus.in1_d_source), 32'h05);
    check("d45_in0_d_valid",  32'(bus.in0_d_valid), 0);
    check("d45_d_ready",      32'(bus.d_ready), 1);
    check("d45_in0_d_data",   bus.in0_d_data, 32'h12345678);
    check("d45_in1_d_denied", 32'(bus.in1_d_denied), 1);
    bus.in1_d_ready = 1'b0;
    @(negedge clock);
    check("d45_d_ready_low",  32'(bus.d_ready), 0);
    bus.d_source = 7'h05; bus.in0_d_ready = 1'b1;
    @(negedge clock);
    check("d05_in0_d_valid",  32'(bus.in0_d_valid), 1);
    check("d05_in1_d_valid",  32'(bus.in1_d_valid), 0);
    check("d05_d_ready",      32'(bus.d_ready), 1);
    check("d05_in0_d_source", 32'(bus.in0_d_source), 32'h05);
    bus.d_valid = 1'b0;
    @(posedge clock);
    #1;

    // Three back-to-back single-beat messages from each requester.
`ifdef TL_A_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) push(7'h10 + 7'(i), 3'd4, 4'd2, 32'h300 + 32'(i), 32'h70 + 32'(i));
    for (int i = 0; i < 3; i++) push(7'h60 + 7'(i), 3'd4, 4'd2, 32'h400 + 32'(i), 32'h80 + 32'(i));
`else
    for (int i = 0; i < 3; i++) begin
      push(7'h10 + 7'(i), 3'd4, 4'd2, 32'h300 + 32'(i), 32'h70 + 32'(i));
      push(7'h60 + 7'(i), 3'd4, 4'd2, 32'h400 + 32'(i), 32'h80 + 32'(i));
    end
`endif
    fork
      begin
        int la;
        for (int i = 0; i < 3; i++)
          send(0, 3'd4, 4'd2, 6'h10 + 6'(i), 32'h300 + 32'(i), 32'h70 + 32'(i), 1, la);
      end
      begin
        int lb;
        for (int i = 0; i < 3; i++)
          send(1, 3'd4, 4'd2, 6'h20 + 6'(i), 32'h400 + 32'(i), 32'h80 + 32'(i), 1, lb);
      end
    join
    drain("three_each");

    // PutFull of size 2 is a single beat: in1 follows immediately.
    push(7'h05, 3'd0, 4'd2, 32'h500, 32'h90);
    push(7'h46, 3'd4, 4'd2, 32'h600, 32'h91);
    fork
      send(0, 3'd0, 4'd2, 6'h05, 32'h500, 32'h90, 1, l0);
      send(1, 3'd4, 4'd2, 6'h06, 32'h600, 32'h91, 1, l1);
    join
    check("lat_in1_after_size2", 32'(l1), 1);
    drain("putfull_size2");

    // PutPartial of size 3 is exactly two beats.
    push(7'h08, 3'd1, 4'd3, 32'h700, 32'h94);
    push(7'h08, 3'd1, 4'd3, 32'h700, 32'h95);
    push(7'h49, 3'd4, 4'd2, 32'h800, 32'h96);
    fork
      send(0, 3'd1, 4'd3, 6'h08, 32'h700, 32'h94, 2, l0);
      send(1, 3'd4, 4'd2, 6'h09, 32'h800, 32'h96, 1, l1);
    join
    check("lat_in1_after_size3", 32'(l1), 2);
    drain("putpartial_size3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tl_a_arb.md
TL_A_ARB -- requirements
Module: tl_a_arb

Interface
REQ-001 SHALL have parameter SRC_W, default 6: requester source-ID width.
REQ-002 SHALL have parameter MAX_SIZE, default 6: largest legal lgSize (64 B) on a 32-bit bus.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports inN_a_valid (input, 1) and inN_a_ready (output, 1), for N=0,1: requester N A-channel handshake.
REQ-006 SHALL have inputs for requester N: inN_a_opcode (3), inN_a_param (3), inN_a_size (4), inN_a_source (SRC_W), inN_a_address (32), inN_a_mask (4), inN_a_data (32), inN_a_corrupt (1).
REQ-007 SHALL have ports out_a_valid (output, 1) and out_a_ready (input, 1): merged A-channel handshake.
REQ-008 SHALL have outputs out_a_opcode, _param, _size, _address, _mask, _data, _corrupt, same widths as REQ-006, plus out_a_source (SRC_W+1).
REQ-009 SHALL have d_valid (input, 1), d_ready (output, 1), d_source (input, SRC_W+1), d_opcode (input, 3), d_size (input, 4), d_data (input, 32) and d_denied (input, 1): D channel from the slave.
REQ-010 SHALL have inN_d_valid (output, 1), inN_d_ready (input, 1), inN_d_source (output, SRC_W) and inN_d_opcode/_size/_data/_denied (outputs): D channel returned to requester N.

Function
REQ-011 SHALL have states IDLE and BURST and a beat counter, 4 bits for the default MAX_SIZE.
REQ-012 SHALL choose the winner combinationally in IDLE: the sole valid requester; if both are valid, the requester named by rr_ptr.
REQ-013 SHALL hold the winner to the locked requester in BURST, whatever the other requester's valid is.
REQ-014 SHALL drive out_a_valid = winner valid, inN_a_ready = out_a_ready & (winner==N), and loser ready = 0.
REQ-015 SHALL pass the winner's payload to the out_a_* fields and drive out_a_source = {winner_id, inN_a_source}.
REQ-016 SHALL treat a beat as multi-beat only when opcode is PutFull(0) or PutPartial(1) and size>2; it then has 2^(size-2) beats. All other opcodes and sizes are single-beat.
REQ-017 SHALL, on an IDLE fire of a multi-beat first beat, move to BURST with counter = beats-2 and lock the winner.
REQ-018 SHALL, on each BURST fire, decrement the counter if it is nonzero; when it is 0, return to IDLE.
REQ-019 SHALL update rr_ptr to the other requester whenever a message completes: a single-beat fire, or the last BURST beat.
REQ-020 SHALL leave state, counter and rr_ptr unchanged on cycles with no fire (valid & ~ready); payload SHALL stay stable while the requester holds it.
REQ-021 SHALL route D by d_source[SRC_W]: inN_d_valid = d_valid & (d_source[SRC_W]==N), d_ready = selected inN_d_ready, inN_d_source = d_source[SRC_W-1:0], other D fields broadcast to both.
REQ-022 SHALL have no combinational path from out_a_ready to out_a_valid.
REQ-023 SHALL have A-channel latency zero: a request presented in IDLE with out_a_ready=1 fires in the same cycle.

Reset
REQ-024 SHALL, while reset_n=0 at a clock edge, set state=IDLE, counter=0 and rr_ptr=0.
REQ-025 SHALL force out_a_valid=0, in0_a_ready=0, in1_a_ready=0, d_ready=0 and inN_d_valid=0 while reset_n=0.
REQ-026 SHALL abandon a burst if reset is asserted mid-burst, and re-arbitrate from IDLE after release.

Configuration
REQ-027 SHALL, when TL_A_ARB_FIXED_PRIO_EN is defined, always give requester 0 priority on contention and remove rr_ptr.
REQ-028 SHALL, when TL_A_ARB_FIXED_PRIO_EN is undefined, use round-robin per REQ-012/REQ-019; burst locking is identical in both builds.

Verification
REQ-029 SHALL cover: both valid, single-beat Get, ready=1 over 2 cycles, round-robin build -> in0 granted, then in1; out_a_source = 0x0_s0, then 0x40|s1.
REQ-030 SHALL cover: in0 PutFull size=4 (4 beats), in1 valid throughout -> 4 consecutive in0 beats, then in1 granted.
REQ-031 SHALL cover: out_a_ready toggling 1,0,1,0 during a 4-beat burst -> lock held, counter decrements only on fires, 4 fires total.
REQ-032 SHALL cover: reset_n low after beat 2 of 4 -> next cycle IDLE, rr_ptr=0, all valid/ready outputs 0.
REQ-033 SHALL cover: d_source=0x45, d_valid=1 -> in1_d_valid=1, in1_d_source=0x05, in0_d_valid=0, d_ready=in1_d_ready.
REQ-034 SHALL cover: with TL_A_ARB_FIXED_PRIO_EN, both valid for 3 single-beat messages -> in0 granted all 3.
